// File: rtl/mc_main_fsm_if.sv
// Control/handshake bundle between the multicycle main FSM and the datapath/memory side.
// master: the FSM. It samples op/zero/mem_ready and drives every control strobe and mux select.
// slave : the datapath/memory side. It drives op/zero/mem_ready and consumes the controls.
//   op[6:0]         instruction opcode from IR
//   zero            ALU zero flag
//   mem_ready       memory completes the current access this cycle
//   mem_req         memory access requested
//   pcwrite         PC load enable
//   adrsrc          0: address=PC, 1: address=ALUOut
//   irwrite         IR/OldPC load
//   regwrite        register file write enable
//   memwrite        memory write request, held until mem_ready
//   resultsrc[1:0]  result mux select
//   alusrca[1:0]    ALU A mux select
//   alusrcb[1:0]    ALU B mux select
//   aluop[1:0]      ALU operation class sent to aludec
//   instr_done      pulse in the last cycle of an instruction
//   trap            FSM is in TRAP
//   trap_cause      0 illegal opcode, 1 memory timeout
interface mc_main_fsm_if;
  logic [6:0] op;
  logic       zero;
  logic       mem_ready;
  logic       mem_req;
  logic       pcwrite;
  logic       adrsrc;
  logic       irwrite;
  logic       regwrite;
  logic       memwrite;
  logic [1:0] resultsrc;
  logic [1:0] alusrca;
  logic [1:0] alusrcb;
  logic [1:0] aluop;
  logic       instr_done;
  logic       trap;
  logic       trap_cause;

  modport master (
    input  op, zero, mem_ready,
    output mem_req, pcwrite, adrsrc, irwrite, regwrite, memwrite,
           resultsrc, alusrca, alusrcb, aluop, instr_done, trap, trap_cause
  );

  modport slave (
    output op, zero, mem_ready,
    input  mem_req, pcwrite, adrsrc, irwrite, regwrite, memwrite,
           resultsrc, alusrca, alusrcb, aluop, instr_done, trap, trap_cause
  );
endinterface

// File: rtl/mc_main_fsm.sv
// Main control FSM of the multicycle RV32I core. It sequences fetch, decode, execute and
// writeback over the shared ALU and memory datapath. It traps on an illegal opcode or on a
// memory access that waits too long.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset
//   bus    mc_main_fsm_if.master, which carries the opcode, flags and memory handshake in,
//          and all control strobes and mux selects out
module mc_main_fsm #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TW      = 8
) (
  input  logic          clk,
  input  logic          reset,
  mc_main_fsm_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_JAL, S_BEQ, S_TRAP
  } state_t;

  // Moore control word. The fetch, pcupdate and branch terms are qualified later by mem_ready or zero.
  typedef struct packed {
    logic       mem_req;
    logic       adrsrc;
    logic       fetch;
    logic       regwrite;
    logic       memwrite;
    logic       pcupdate;
    logic       branch;
    logic [1:0] resultsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
  } ctl_t;

  // Control word for each state; fields not set here stay 0.
  function automatic ctl_t ctl_of(state_t s);
    ctl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_req = 1'b1; c.fetch = 1'b1; c.alusrcb = 2'b10; c.resultsrc = 2'b10;
      end
      S_DECODE:   begin c.alusrca = 2'b01; c.alusrcb = 2'b01; end
      S_MEMADR:   begin c.alusrca = 2'b10; c.alusrcb = 2'b01; end
      S_MEMREAD:  begin c.mem_req = 1'b1; c.adrsrc = 1'b1; end
      S_MEMWB:    begin c.resultsrc = 2'b01; c.regwrite = 1'b1; end
      S_MEMWRITE: begin c.mem_req = 1'b1; c.adrsrc = 1'b1; c.memwrite = 1'b1; end
      S_EXECR:    begin c.alusrca = 2'b10; c.alusrcb = 2'b00; c.aluop = 2'b10; end
      S_EXECI:    begin c.alusrca = 2'b10; c.alusrcb = 2'b01; c.aluop = 2'b10; end
      S_ALUWB:    begin c.regwrite = 1'b1; end
      S_JAL:      begin c.alusrca = 2'b01; c.alusrcb = 2'b10; c.pcupdate = 1'b1; end
      S_BEQ:      begin c.alusrca = 2'b10; c.aluop = 2'b01; c.branch = 1'b1; end
      default:    c = '0;
    endcase
    return c;
  endfunction

  state_t        state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  ctl_t          ctl_q;
  logic          trap_q;
  logic          cause_q, cause_d;
  logic          waiting_c;
  logic          timeout_c;

  // A memory state is stalled on the handshake.
  assign waiting_c = ctl_q.mem_req & ~bus.mem_ready;
  // mem_ready in the expiry cycle still lets the access complete.
  assign timeout_c = (TIMEOUT != 0) && waiting_c && (cnt_q == TW'(TIMEOUT));

  // Next state, trap cause and wait counter.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_FETCH:    if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.op)
          7'b0000011, 7'b0100011: state_d = S_MEMADR;
          7'b0110011:             state_d = S_EXECR;
          7'b0010011:             state_d = S_EXECI;
          7'b1101111:             state_d = S_JAL;
          7'b1100011:             state_d = S_BEQ;
          default: begin
            state_d = S_TRAP;
            cause_d = 1'b0;
          end
        endcase
      end
      S_MEMADR:   state_d = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (bus.mem_ready) state_d = S_MEMWB;
      S_MEMWRITE: if (bus.mem_ready) state_d = S_FETCH;
      S_MEMWB, S_ALUWB, S_BEQ: state_d = S_FETCH;
      S_EXECR, S_EXECI, S_JAL: state_d = S_ALUWB;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_FETCH;
    endcase
    if (timeout_c) begin
      state_d = S_TRAP;
      cause_d = 1'b1;
    end
    // The counter restarts on any state change and saturates instead of wrapping.
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (waiting_c && (cnt_q != {TW{1'b1}})) begin
      cnt_d = cnt_q + TW'(1);
    end
  end

  // State and registered control word. The control word is decoded from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      ctl_q   <= ctl_of(S_FETCH);
      trap_q  <= 1'b0;
      cause_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctl_q   <= ctl_of(state_d);
      trap_q  <= (state_d == S_TRAP);
      cause_q <= cause_d;
    end
  end

  // Strobes are held low while reset is high. Mux selects already show the FETCH values.
  assign bus.mem_req    = ctl_q.mem_req & ~reset;
  assign bus.irwrite    = ctl_q.fetch & bus.mem_ready & ~reset;
  assign bus.pcwrite    = ((ctl_q.fetch & bus.mem_ready) | ctl_q.pcupdate |
                           (ctl_q.branch & bus.zero)) & ~reset;
  assign bus.regwrite   = ctl_q.regwrite & ~reset;
  assign bus.memwrite   = ctl_q.memwrite & ~reset;
  assign bus.adrsrc     = ctl_q.adrsrc;
  assign bus.resultsrc  = ctl_q.resultsrc;
  assign bus.alusrca    = ctl_q.alusrca;
  assign bus.alusrcb    = ctl_q.alusrcb;
  assign bus.aluop      = ctl_q.aluop;
  assign bus.instr_done = (state_q != S_FETCH) && (state_d == S_FETCH) && !reset;
  assign bus.trap       = trap_q;
  assign bus.trap_cause = cause_q;

endmodule

// File: tb/tb_mc_main_fsm.sv
// Directed testbench for mc_main_fsm. Each instruction is turned into a cycle script of
// expected phases from its class, fetch wait cycles and memory wait cycles. Every cycle
// is compared against that script. Literal pins fix key cycles.
module tb_mc_main_fsm;
  localparam int unsigned TB_TO = 4;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  logic clk = 1'b0;
  logic rst;

  mc_main_fsm_if bus();

  mc_main_fsm #(.TIMEOUT(TB_TO), .TW(8)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       mem_req;
    logic       pcwrite;
    logic       adrsrc;
    logic       irwrite;
    logic       regwrite;
    logic       memwrite;
    logic [1:0] resultsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic       instr_done;
    logic       trap;
    logic       trap_cause;
  } obs_t;

  typedef enum int {
    P_RESET, P_FETCH, P_DECODE, P_MEMADR, P_MEMREAD, P_MEMWB, P_MEMWRITE,
    P_EXECR, P_EXECI, P_ALUWB, P_JAL, P_BEQ, P_TRAP
  } phase_e;

  typedef struct {
    phase_e     p;
    logic       rst;
    logic [6:0] op;
    logic       z;
    logic       rdy;
    obs_t       exp;
    bit         lit;
    obs_t       lmask;
    obs_t       lval;
  } vec_t;

  vec_t       vq[$];
  logic [6:0] cur_op;
  logic       cur_z;
  int         n_vec = 0;
  int         n_bad = 0;

  // Expected outputs for one cycle of a given phase, taken from the state output table.
  function automatic obs_t ph(phase_e p, logic rdy, logic z, logic done, logic cause);
    obs_t o;
    o = '0;
    case (p)
      P_RESET:    begin o.alusrcb = 2'b10; o.resultsrc = 2'b10; end
      P_FETCH:    begin
        o.mem_req = 1'b1; o.alusrcb = 2'b10; o.resultsrc = 2'b10;
        o.irwrite = rdy; o.pcwrite = rdy;
      end
      P_DECODE:   begin o.alusrca = 2'b01; o.alusrcb = 2'b01; end
      P_MEMADR:   begin o.alusrca = 2'b10; o.alusrcb = 2'b01; end
      P_MEMREAD:  begin o.mem_req = 1'b1; o.adrsrc = 1'b1; end
      P_MEMWB:    begin o.resultsrc = 2'b01; o.regwrite = 1'b1; end
      P_MEMWRITE: begin o.mem_req = 1'b1; o.adrsrc = 1'b1; o.memwrite = 1'b1; end
      P_EXECR:    begin o.alusrca = 2'b10; o.aluop = 2'b10; end
      P_EXECI:    begin o.alusrca = 2'b10; o.alusrcb = 2'b01; o.aluop = 2'b10; end
      P_ALUWB:    begin o.regwrite = 1'b1; end
      P_JAL:      begin o.alusrca = 2'b01; o.alusrcb = 2'b10; o.pcwrite = 1'b1; end
      P_BEQ:      begin o.alusrca = 2'b10; o.aluop = 2'b01; o.pcwrite = z; end
      P_TRAP:     begin o.trap = 1'b1; o.trap_cause = cause; end
      default:    o = '0;
    endcase
    o.instr_done = done;
    return o;
  endfunction

  task automatic push(phase_e p, logic r, logic rdy, logic done, logic cause);
    vec_t v;
    v.p     = p;
    v.rst   = r;
    v.op    = cur_op;
    v.z     = cur_z;
    v.rdy   = rdy;
    v.exp   = ph(p, rdy, cur_z, done, cause);
    v.lit   = 1'b0;
    v.lmask = '0;
    v.lval  = '0;
    vq.push_back(v);
  endtask

  task automatic pin_at(int idx, obs_t m, obs_t val);
    vec_t v;
    v       = vq[idx];
    v.lit   = 1'b1;
    v.lmask = m;
    v.lval  = val;
    vq[idx] = v;
  endtask

  // A handshake phase that stalls w cycles. Past the timeout it traps after TB_TO+1 stalled cycles.
  task automatic waits(phase_e p, int w, logic done_last, output bit trapped);
    trapped = 1'b0;
    if (w > int'(TB_TO)) begin
      for (int i = 0; i <= int'(TB_TO); i++) push(p, 1'b0, 1'b0, 1'b0, 1'b0);
      trapped = 1'b1;
    end else begin
      for (int i = 0; i < w; i++) push(p, 1'b0, 1'b0, 1'b0, 1'b0);
      push(p, 1'b0, 1'b1, done_last, 1'b0);
    end
  endtask

  // n cycles in TRAP with mem_ready toggling, then one reset cycle.
  task automatic trap_run(int n, logic cause);
    for (int i = 0; i < n; i++) push(P_TRAP, 1'b0, logic'(i[0]), 1'b0, cause);
    push(P_RESET, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // Builds the full cycle script for one instruction.
  task automatic run(logic [6:0] op, logic z, int fw, int mw, int ntrap);
    bit t;
    cur_op = op;
    cur_z  = z;
    waits(P_FETCH, fw, 1'b0, t);
    if (t) begin
      trap_run(ntrap, 1'b1);
    end else begin
      push(P_DECODE, 1'b0, 1'b1, 1'b0, 1'b0);
      case (op)
        OP_R:   begin push(P_EXECR, 1'b0, 1'b1, 1'b0, 1'b0); push(P_ALUWB, 1'b0, 1'b1, 1'b1, 1'b0); end
        OP_I:   begin push(P_EXECI, 1'b0, 1'b1, 1'b0, 1'b0); push(P_ALUWB, 1'b0, 1'b1, 1'b1, 1'b0); end
        OP_JAL: begin push(P_JAL, 1'b0, 1'b1, 1'b0, 1'b0); push(P_ALUWB, 1'b0, 1'b1, 1'b1, 1'b0); end
        OP_BEQ: push(P_BEQ, 1'b0, 1'b1, 1'b1, 1'b0);
        OP_LW: begin
          push(P_MEMADR, 1'b0, 1'b1, 1'b0, 1'b0);
          waits(P_MEMREAD, mw, 1'b0, t);
          if (t) trap_run(ntrap, 1'b1);
          else   push(P_MEMWB, 1'b0, 1'b1, 1'b1, 1'b0);
        end
        OP_SW: begin
          push(P_MEMADR, 1'b0, 1'b1, 1'b0, 1'b0);
          waits(P_MEMWRITE, mw, 1'b1, t);
          if (t) trap_run(ntrap, 1'b1);
        end
        default: trap_run(ntrap, 1'b0);
      endcase
    end
  endtask

  initial begin
    obs_t m;
    obs_t v;
    obs_t got;
    int   s;
    bit   t;

    rst           = 1'b1;
    bus.op        = 7'd0;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b0;

    // Power-on reset: no strobe, no trap.
    cur_op = 7'd0; cur_z = 1'b1;
    push(P_RESET, 1'b1, 1'b1, 1'b0, 1'b0);
    push(P_RESET, 1'b1, 1'b0, 1'b0, 1'b0);
    m = '0; m.mem_req = 1'b1; m.pcwrite = 1'b1; m.irwrite = 1'b1; m.memwrite = 1'b1; m.trap = 1'b1;
    pin_at(0, m, '0);

    // add with zero-wait memory: 4 cycles.
    s = vq.size();
    run(OP_R, 1'b1, 0, 0, 0);
    m = '0; m.pcwrite = 1'b1; v = '0; v.pcwrite = 1'b1;
    pin_at(s, m, v);
    m = '0; m.aluop = 2'b11; v = '0; v.aluop = 2'b10;
    pin_at(s + 2, m, v);
    m = '0; m.regwrite = 1'b1; m.instr_done = 1'b1; v = m;
    pin_at(s + 3, m, v);

    run(OP_I, 1'b0, 2, 0, 0);
    run(OP_LW, 1'b0, 0, 3, 0);
    run(OP_SW, 1'b1, 1, 0, 0);
    run(OP_SW, 1'b0, 0, 2, 0);

    // beq taken and not taken.
    s = vq.size();
    run(OP_BEQ, 1'b1, 0, 0, 0);
    m = '0; m.pcwrite = 1'b1; m.aluop = 2'b11; v = '0; v.pcwrite = 1'b1; v.aluop = 2'b01;
    pin_at(s + 2, m, v);
    s = vq.size();
    run(OP_BEQ, 1'b0, 0, 0, 0);
    v = '0; v.aluop = 2'b01;
    pin_at(s + 2, m, v);

    run(OP_JAL, 1'b0, 0, 0, 0);

    // Illegal opcode: trap with cause 0 for 20 cycles, then reset.
    s = vq.size();
    run(7'b1111111, 1'b1, 0, 0, 20);
    m = '0; m.trap = 1'b1; m.trap_cause = 1'b1; v = '0; v.trap = 1'b1;
    pin_at(s + 2, m, v);
    s = vq.size();
    run(OP_R, 1'b0, 0, 0, 0);
    m = '0; m.trap = 1'b1; m.mem_req = 1'b1; v = '0; v.mem_req = 1'b1;
    pin_at(s, m, v);
    run(7'b0110111, 1'b0, 0, 0, 3);

    // Fetch timeout: 5 stalled FETCH cycles, then TRAP with cause 1.
    s = vq.size();
    run(OP_R, 1'b0, 5, 0, 3);
    m = '0; m.trap = 1'b1; m.trap_cause = 1'b1; v = m;
    pin_at(s + 5, m, v);
    // Ready on the 5th cycle wins over the timeout.
    run(OP_R, 1'b0, 4, 0, 0);
    // Timeout while stalled in MEMREAD.
    run(OP_LW, 1'b0, 0, 7, 3);
    run(OP_SW, 1'b0, 0, 4, 0);

    // Reset while stalled in MEMWRITE: memwrite drops right away, and FETCH follows release.
    cur_op = OP_SW; cur_z = 1'b0;
    waits(P_FETCH, 0, 1'b0, t);
    push(P_DECODE, 1'b0, 1'b1, 1'b0, 1'b0);
    push(P_MEMADR, 1'b0, 1'b1, 1'b0, 1'b0);
    push(P_MEMWRITE, 1'b0, 1'b0, 1'b0, 1'b0);
    push(P_MEMWRITE, 1'b0, 1'b0, 1'b0, 1'b0);
    push(P_RESET, 1'b1, 1'b0, 1'b0, 1'b0);
    m = '0; m.memwrite = 1'b1; m.mem_req = 1'b1; m.adrsrc = 1'b1;
    pin_at(vq.size() - 1, m, '0);
    run(OP_R, 1'b1, 0, 0, 0);
    run(OP_BEQ, 1'b1, 1, 0, 0);

    // Apply inputs just after each rising edge and compare at the falling edge.
    foreach (vq[i]) begin
      @(posedge clk);
      #1;
      rst           = vq[i].rst;
      bus.op        = vq[i].op;
      bus.zero      = vq[i].z;
      bus.mem_ready = vq[i].rdy;
      @(negedge clk);
      got = {bus.mem_req, bus.pcwrite, bus.adrsrc, bus.irwrite, bus.regwrite, bus.memwrite,
             bus.resultsrc, bus.alusrca, bus.alusrcb, bus.aluop,
             bus.instr_done, bus.trap, bus.trap_cause};
      n_vec++;
      if (got !== vq[i].exp) begin
        n_bad++;
        $display("FAIL %s[%0d]: got %b want %b", vq[i].p.name(), i, got, vq[i].exp);
      end
      if (vq[i].lit) begin
        n_vec++;
        if ((got & vq[i].lmask) !== vq[i].lval) begin
          n_bad++;
          $display("FAIL pin_%s[%0d]: got %b want %b under mask %b",
                   vq[i].p.name(), i, got & vq[i].lmask, vq[i].lval, vq[i].lmask);
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
